// File: rtl/video_ip_pkg.sv
// Shared constants for the video IP family: pattern selects, RGB565 color bars,
// register addresses and the pattern-source FSM state type.
package video_ip_pkg;

  localparam logic [2:0] PAT_SOLID   = 3'd0;
  localparam logic [2:0] PAT_BARS    = 3'd1;
  localparam logic [2:0] PAT_RAMP    = 3'd2;
  localparam logic [2:0] PAT_CHECKER = 3'd3;
  localparam logic [2:0] PAT_COUNTER = 3'd4;

  localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
  localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
  localparam logic [15:0] RGB_CYAN    = 16'h07FF;
  localparam logic [15:0] RGB_GREEN   = 16'h07E0;
  localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
  localparam logic [15:0] RGB_RED     = 16'hF800;
  localparam logic [15:0] RGB_BLUE    = 16'h001F;
  localparam logic [15:0] RGB_BLACK   = 16'h0000;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PATTERN = 2'd1;
  localparam logic [1:0] ADDR_COLOR   = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } src_state_t;

  // Bars run left to right in classic SMPTE-like order.
  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    logic [15:0] c;
    case (idx)
      3'd0:    c = RGB_WHITE;
      3'd1:    c = RGB_YELLOW;
      3'd2:    c = RGB_CYAN;
      3'd3:    c = RGB_GREEN;
      3'd4:    c = RGB_MAGENTA;
      3'd5:    c = RGB_RED;
      3'd6:    c = RGB_BLUE;
      default: c = RGB_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/video_pattern_pixel.sv
// Combinational pixel generator: maps (sel, color, x, y, bar index, pixel index)
// to one RGB565 value.
module video_pattern_pixel
  import video_ip_pkg::*;
(
  input  logic [2:0]  sel,
  input  logic [15:0] color,
  input  logic [11:0] x,
  input  logic [11:0] y,
  input  logic [2:0]  bar_idx,
  input  logic [15:0] pix_idx,
  output logic [15:0] pixel
);

  // Only a few coordinate bits feed the ramp and checker patterns.
  logic unused_coords;
  assign unused_coords = ^{x[11:8], x[1:0], y[11:5], y[3:0]};

  always_comb begin
    pixel = color;
    case (sel)
      PAT_BARS:    pixel = bar_color(bar_idx);
      PAT_RAMP:    pixel = {x[7:3], x[7:2], x[7:3]};
      PAT_CHECKER: pixel = (x[4] ^ y[4]) ? color : ~color;
      PAT_COUNTER: pixel = pix_idx;
      default:     pixel = color;
    endcase
  end

endmodule

// File: rtl/video_pattern_source.sv
// Avalon-ST RGB565 test-frame source with Avalon-MM control/status registers.
// Optional frame-done interrupt enabled by defining VIDEO_PATTERN_IRQ_EN.
module video_pattern_source
  import video_ip_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [15:0] data_out,
  output logic        startofpacket_out,
  output logic        endofpacket_out,
  output logic        irq_sender
);

  localparam logic [11:0] X_LAST   = 12'(WIDTH - 1);
  localparam logic [11:0] Y_LAST   = 12'(HEIGHT - 1);
  localparam logic [11:0] BAR_LAST = 12'(WIDTH / 8 - 1);

  src_state_t  state;
  logic        enable, single_shot;
  logic [2:0]  pat_sel, sh_sel;
  logic [15:0] color, sh_color;
  logic [15:0] frame_count;
  logic        irq_en, irq_pending;
  logic [11:0] x, y, bar_cnt;
  logic [2:0]  bar_idx;
  logic [15:0] pix_idx;
  logic [15:0] pixel;

  logic unused_wdata;
  assign unused_wdata = ^writedata[31:16];

  // Handshake: a pixel moves on every edge where valid_out and ready_in are both
  // high; while stalled the output register holds data/SOP/EOP unchanged.
  logic mm_wr, mm_rd, ctrl_wr, pat_wr, color_wr, status_wr;
  logic xfer, eop_xfer, load, busy;
  assign mm_wr     = chipselect & write;
  assign mm_rd     = chipselect & read;
  assign ctrl_wr   = mm_wr && (address == ADDR_CTRL);
  assign pat_wr    = mm_wr && (address == ADDR_PATTERN);
  assign color_wr  = mm_wr && (address == ADDR_COLOR);
  assign status_wr = mm_wr && (address == ADDR_STATUS);
  assign xfer      = valid_out & ready_in;
  assign eop_xfer  = xfer & endofpacket_out;
  assign load      = ~valid_out | ready_in;
  assign busy      = (state == ST_ACTIVE);

  logic        en_next;
  logic [15:0] fc_next;
  always_comb begin
    en_next = enable;
    if (eop_xfer && single_shot) en_next = 1'b0;
    if (ctrl_wr) en_next = writedata[0];
    fc_next = frame_count;
    if (eop_xfer) fc_next = frame_count + 16'd1;
    if (status_wr && writedata[0]) fc_next = 16'd0;
  end

  logic [31:0] rd_mux;
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_CTRL:    rd_mux = {29'd0, single_shot, irq_en, enable};
      ADDR_PATTERN: rd_mux = {29'd0, pat_sel};
      ADDR_COLOR:   rd_mux = {16'd0, color};
      default:      rd_mux = {frame_count, 14'd0, irq_pending, busy};
    endcase
  end

  video_pattern_pixel u_pixel (
    .sel     (sh_sel),
    .color   (sh_color),
    .x       (x),
    .y       (y),
    .bar_idx (bar_idx),
    .pix_idx (pix_idx),
    .pixel   (pixel)
  );

`ifdef VIDEO_PATTERN_IRQ_EN
  logic pend_next, irq_en_next;
  always_comb begin
    irq_en_next = ctrl_wr ? writedata[1] : irq_en;
    pend_next   = irq_pending;
    if (status_wr && writedata[1]) pend_next = 1'b0;
    if (eop_xfer) pend_next = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en      <= 1'b0;
      irq_pending <= 1'b0;
      irq_sender  <= 1'b0;
    end else begin
      irq_en      <= irq_en_next;
      irq_pending <= pend_next;
      irq_sender  <= pend_next & irq_en_next;
    end
  end
`else
  assign irq_en      = 1'b0;
  assign irq_pending = 1'b0;
  assign irq_sender  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= ST_IDLE;
      enable            <= 1'b0;
      single_shot       <= 1'b0;
      pat_sel           <= '0;
      color             <= '0;
      frame_count       <= '0;
      sh_sel            <= '0;
      sh_color          <= '0;
      x                 <= '0;
      y                 <= '0;
      bar_cnt           <= '0;
      bar_idx           <= '0;
      pix_idx           <= '0;
      valid_out         <= 1'b0;
      data_out          <= '0;
      startofpacket_out <= 1'b0;
      endofpacket_out   <= 1'b0;
      readdata          <= '0;
    end else begin
      enable      <= en_next;
      frame_count <= fc_next;
      if (ctrl_wr)  single_shot <= writedata[2];
      if (pat_wr)   pat_sel     <= writedata[2:0];
      if (color_wr) color       <= writedata[15:0];
      readdata <= mm_rd ? rd_mux : '0;

      case (state)
        ST_IDLE: begin
          valid_out         <= 1'b0;
          startofpacket_out <= 1'b0;
          endofpacket_out   <= 1'b0;
          if (enable) begin
            sh_sel   <= pat_sel;
            sh_color <= color;
            x        <= '0;
            y        <= '0;
            bar_cnt  <= '0;
            bar_idx  <= '0;
            pix_idx  <= '0;
            state    <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (eop_xfer) begin
            // Frame done: relatch config and restart counters right away so a
            // still-enabled source resumes after a single empty cycle.
            valid_out         <= 1'b0;
            startofpacket_out <= 1'b0;
            endofpacket_out   <= 1'b0;
            sh_sel            <= pat_sel;
            sh_color          <= color;
            x                 <= '0;
            y                 <= '0;
            bar_cnt           <= '0;
            bar_idx           <= '0;
            pix_idx           <= '0;
            if (!en_next) state <= ST_IDLE;
          end else if (load) begin
            valid_out         <= 1'b1;
            data_out          <= pixel;
            startofpacket_out <= (x == 12'd0) && (y == 12'd0);
            endofpacket_out   <= (x == X_LAST) && (y == Y_LAST);
            pix_idx           <= pix_idx + 16'd1;
            if (x == X_LAST) begin
              x       <= '0;
              bar_cnt <= '0;
              bar_idx <= '0;
              y       <= (y == Y_LAST) ? 12'd0 : y + 12'd1;
            end else begin
              x <= x + 12'd1;
              if (bar_cnt == BAR_LAST) begin
                bar_cnt <= '0;
                bar_idx <= bar_idx + 3'd1;
              end else begin
                bar_cnt <= bar_cnt + 12'd1;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_pattern_source.sv
// Directed bench for video_pattern_source on a reduced 64x4 frame; expected
// pixels come from an independent coordinate-based pattern model.
module tb_video_pattern_source;
  import video_ip_pkg::*;

  localparam int TW = 64;
  localparam int TH = 4;
  localparam int TN = TW * TH;
`ifdef VIDEO_PATTERN_IRQ_EN
  localparam logic IRQ = 1'b1;
`else
  localparam logic IRQ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        chipselect = 1'b0;
  logic [1:0]  address = '0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic        valid_out;
  logic        ready_in = 1'b0;
  logic [15:0] data_out;
  logic        startofpacket_out;
  logic        endofpacket_out;
  logic        irq_sender;

  int n_cmp = 0;
  int n_err = 0;
  logic [17:0] exp_q[$];

  video_pattern_source #(.WIDTH(TW), .HEIGHT(TH)) dut (
    .clk               (clk),
    .reset             (reset),
    .chipselect        (chipselect),
    .address           (address),
    .write             (write),
    .writedata         (writedata),
    .read              (read),
    .readdata          (readdata),
    .valid_out         (valid_out),
    .ready_in          (ready_in),
    .data_out          (data_out),
    .startofpacket_out (startofpacket_out),
    .endofpacket_out   (endofpacket_out),
    .irq_sender        (irq_sender)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_pixel(input logic [2:0] sel, input logic [15:0] col,
                                            input int x, input int y);
    logic [7:0]  xb, yb;
    logic [15:0] p;
    xb = 8'(x);
    yb = 8'(y);
    case (sel)
      3'd1: begin
        case (x / (TW / 8))
          0: p = 16'hFFFF;
          1: p = 16'hFFE0;
          2: p = 16'h07FF;
          3: p = 16'h07E0;
          4: p = 16'hF81F;
          5: p = 16'hF800;
          6: p = 16'h001F;
          default: p = 16'h0000;
        endcase
      end
      3'd2: p = {xb[7:3], xb[7:2], xb[7:3]};
      3'd3: p = (xb[4] ^ yb[4]) ? col : ~col;
      3'd4: p = 16'(y * TW + x);
      default: p = col;
    endcase
    return p;
  endfunction

  // driver tasks
  task automatic mm_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic mm_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic fill_frame(input logic [2:0] sel, input logic [15:0] col);
    for (int i = 0; i < TN; i++)
      exp_q.push_back({i == 0, i == TN - 1, exp_pixel(sel, col, i % TW, i / TW)});
  endtask

  // Consumes one frame from exp_q; optionally issues one MM write on the edge
  // that transfers pixel act_at. Returns at the negedge after the EOP edge.
  task automatic run_frame(input bit rnd, input int act_at, input logic [1:0] act_addr,
                           input logic [31:0] act_data, output int n_xfer);
    int cyc = 0, first = -1;
    bit done = 1'b0, stalled = 1'b0;
    logic [17:0] held, exp;
    n_xfer = 0;
    while (!done && cyc < 4000) begin
      ready_in = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      chipselect = 1'b0; write = 1'b0;
      if (stalled)
        check("stall_hold", {valid_out, startofpacket_out, endofpacket_out, data_out}, {1'b1, held});
      stalled = valid_out && !ready_in;
      held = {startofpacket_out, endofpacket_out, data_out};
      if (valid_out && ready_in) begin
        if (first < 0) first = cyc;
        if (n_xfer == act_at) begin
          chipselect = 1'b1; write = 1'b1; address = act_addr; writedata = act_data;
        end
        if (exp_q.size() == 0) exp = 18'h3FFFF;
        else exp = exp_q.pop_front();
        check($sformatf("pixel%0d", n_xfer), {startofpacket_out, endofpacket_out, data_out}, exp);
        n_xfer++;
        if (endofpacket_out) begin
          done = 1'b1;
          if (!rnd) check("no_bubble_span", cyc - first + 1, TN);
        end
      end
      cyc++;
      @(negedge clk);
    end
    chipselect = 1'b0; write = 1'b0;
    check("frame_done_in_budget", done, 1);
  endtask

  initial begin
    logic [31:0] rd;
    int n, vcnt;
    bit eop_seen;

    // reset block
    repeat (3) @(negedge clk);
    check("rst_valid", valid_out, 0);
    check("rst_data", data_out, 0);
    check("rst_sop_eop", {startofpacket_out, endofpacket_out}, 0);
    check("rst_irq", irq_sender, 0);
    check("rst_readdata", readdata, 0);
    reset = 1'b1;
    mm_read(ADDR_STATUS, rd);
    check("rst_status", rd, 0);

    // color bars, start latency, no bubbles, 1-cycle gap
    ready_in = 1'b1;
    mm_write(ADDR_PATTERN, 32'd1);
    mm_write(ADDR_CTRL, 32'd1);
    check("lat_n0_valid", valid_out, 0);
    @(negedge clk);
    check("lat_n1_valid", valid_out, 0);
    @(negedge clk);
    check("lat_n2_first", {valid_out, startofpacket_out, data_out}, {1'b1, 1'b1, 16'hFFFF});
    fill_frame(3'd1, 16'h0);
    run_frame(1'b0, -1, 2'd0, 32'd0, n);
    check("bars_count", n, TN);
    check("gap_idle", valid_out, 0);
    fill_frame(3'd1, 16'h0);
    @(negedge clk);
    check("gap_restart_sop", {valid_out, startofpacket_out}, 2'b11);
    run_frame(1'b0, 10, ADDR_CTRL, 32'd0, n);
    vcnt = 0;
    repeat (20) begin
      if (valid_out) vcnt++;
      @(negedge clk);
    end
    check("disable_stays_idle", vcnt, 0);
    mm_read(ADDR_STATUS, rd);
    check("status_fc2", rd, {16'd2, 16'd0});

    // solid color under random backpressure
    mm_write(ADDR_PATTERN, 32'd0);
    mm_write(ADDR_COLOR, 32'h1234);
    mm_write(ADDR_CTRL, 32'd1);
    fill_frame(3'd0, 16'h1234);
    run_frame(1'b1, 5, ADDR_CTRL, 32'd0, n);
    check("solid_rnd_count", n, TN);
    check("solid_q_empty", exp_q.size(), 0);

    // single-shot checkerboard with irq; irq clear lands on the EOP edge
    mm_write(ADDR_STATUS, 32'd1);
    mm_write(ADDR_PATTERN, 32'd3);
    mm_write(ADDR_CTRL, 32'd7);
    fill_frame(3'd3, 16'h1234);
    run_frame(1'b1, TN - 1, ADDR_STATUS, 32'd2, n);
    check("irq_after_eop", irq_sender, IRQ);
    vcnt = 0;
    repeat (10) begin
      if (valid_out) vcnt++;
      @(negedge clk);
    end
    check("single_shot_idle", vcnt, 0);
    mm_read(ADDR_CTRL, rd);
    check("ctrl_autoclear", rd, {29'd0, 1'b1, IRQ, 1'b0});
    mm_read(ADDR_STATUS, rd);
    check("status_fc1_irq", rd, {16'd1, 14'd0, IRQ, 1'b0});
    check("irq_held", irq_sender, IRQ);
    mm_write(ADDR_STATUS, 32'd2);
    check("irq_cleared", irq_sender, 0);
    mm_read(ADDR_STATUS, rd);
    check("status_pending_clr", rd, {16'd1, 16'd0});

    // counter frame with mid-frame pattern change; fc clear on EOP edge wins
    mm_write(ADDR_PATTERN, 32'd4);
    mm_write(ADDR_CTRL, 32'd1);
    fill_frame(3'd4, 16'h0);
    run_frame(1'b0, 20, ADDR_PATTERN, 32'd0, n);
    fill_frame(3'd0, 16'h1234);
    run_frame(1'b0, TN - 1, ADDR_STATUS, 32'd1, n);
    fill_frame(3'd0, 16'h1234);
    run_frame(1'b0, 2, ADDR_CTRL, 32'd0, n);
    mm_read(ADDR_STATUS, rd);
    check("fc_clear_wins", rd, {16'd1, 16'd0});

    // ctrl write beats single-shot auto-clear; ramp and select 6
    mm_write(ADDR_PATTERN, 32'd2);
    mm_write(ADDR_CTRL, 32'd5);
    fill_frame(3'd2, 16'h0);
    run_frame(1'b1, TN - 1, ADDR_CTRL, 32'd5, n);
    check("write_wins_gap", valid_out, 0);
    fill_frame(3'd2, 16'h0);
    run_frame(1'b1, -1, 2'd0, 32'd0, n);
    check("ramp2_count", n, TN);
    vcnt = 0;
    repeat (8) begin
      if (valid_out) vcnt++;
      @(negedge clk);
    end
    check("ramp_single_idle", vcnt, 0);
    mm_write(ADDR_PATTERN, 32'd6);
    mm_write(ADDR_COLOR, 32'hABCD);
    mm_write(ADDR_CTRL, 32'd5);
    fill_frame(3'd6, 16'hABCD);
    run_frame(1'b0, -1, 2'd0, 32'd0, n);

    // asynchronous reset mid-frame
    mm_write(ADDR_PATTERN, 32'd4);
    mm_write(ADDR_CTRL, 32'd1);
    ready_in = 1'b1;
    n = 0;
    while (!valid_out && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rst_test_started", valid_out, 1);
    eop_seen = 1'b0;
    repeat (100) begin
      if (endofpacket_out) eop_seen = 1'b1;
      @(negedge clk);
    end
    check("no_eop_before_rst", eop_seen, 0);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_outputs", {valid_out, startofpacket_out, endofpacket_out, data_out}, 0);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    mm_read(ADDR_CTRL, rd);
    check("rst_ctrl_cleared", rd, 0);
    check("rst_idle_valid", valid_out, 0);
    mm_write(ADDR_PATTERN, 32'd4);
    mm_write(ADDR_CTRL, 32'd1);
    fill_frame(3'd4, 16'h0);
    run_frame(1'b0, 2, ADDR_CTRL, 32'd0, n);
    check("post_rst_count", n, TN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
